sdram_bram_responder: RTL
=========================

// Module: sdram_bram_responder
// PURPOSE
// - Synthesizable BRAM-backed responder for the SDRAM controller user interface (read/write/refresh/busy).
// - Drop-in replacement for the SDRAM controller behind the DRAM front end, for FPGA bring-up without SDRAM.
// - Emulates controller timing: busy windows, refresh cycles, init delay.
// PARAMETERS
// - DEPTH_WORDS   4096  32-bit words in array; index = addr[31:2] modulo DEPTH_WORDS (power of 2)
// - READ_LAT      4     busy cycles per read (>=2)
// - WRITE_LAT     3     busy cycles per write (>=2)
// - REFRESH_LAT   8     busy cycles per refresh (>=2)
// - INIT_CYCLES   16    cycles after reset before mem_initialized (>=1)
// - REFRESH_MAX   405   max cycles between refreshes (watchdog, optional feature)
// - PRELOAD_FILE  ""    $readmemh image for the array; empty = no preload
// PORTS
// - clk              in   1   system clock
// - rst              in   1   synchronous reset, active high
// - read             in   1   read request (level; initiator drops it on seeing busy)
// - write            in   1   write request (level; same rule)
// - refresh          in   1   refresh request (level; same rule)
// - addr             in   32  byte address; [1:0] ignored
// - din              in   32  write data
// - mask             in   4   byte mask, active LOW per byte: 1 = byte NOT written
// - dout             out  32  read data
// - busy             out  1   responder busy
// - mem_initialized  out  1   high once init delay elapsed
// - fail             out  1   sticky protocol-violation flag
// - total_written    out  32  count of completed writes, wraps at 2^32
// - refresh_late     out  1   sticky refresh-deadline miss (0 without feature)
// BEHAVIOUR
// - Reset: busy=1, dout=0, mem_initialized=0, fail=0, total_written=0, refresh_late=0; state->INIT.
//   Array contents NOT cleared by reset. Reset mid-operation aborts the op; a pending write is dropped.
// - INIT: busy=1; after INIT_CYCLES cycles set mem_initialized=1, busy=0, ->IDLE. Requests ignored.
// - IDLE: busy=0. Priority at sampling edge N: write > read > refresh. Capture addr/din/mask at N.
//   Simultaneous write+read or write+refresh: serve write only; set fail=1.
//   Lower-priority requests still high at completion follow the RELEASE rule.
// - RD/WR/REF: busy=1 for exactly LAT cycles (N+1..N+LAT); return to IDLE at edge N+LAT+1.
//   - Read: dout loaded from array at the completion edge (busy falls in the same cycle); held until next read.
//   - Write: bytes with mask[b]=0 updated at the completion edge; total_written+1 on that edge.
//   - Refresh: no array access; clears refresh watchdog.
// - Handshake: initiator must drop the serviced request while busy=1. Responder tracks "seen low"
//   per op. If request still high at completion: fail=1, ->RELEASE (busy=1) until all requests low, then IDLE.
//   No new op is started from a request that never dropped.
// - Address wrap: index = addr[log2(DEPTH_WORDS)+1:2]; out-of-range addresses alias, no error.
// - fail and refresh_late clear only on rst.
// CONFIGURATION
// - SDRAM_BRAM_REFRESH_CHECK_EN defined: counter since last completed refresh (reset to 0 by rst and refresh
//   completion, saturating). Counter > REFRESH_MAX sets refresh_late=1 (sticky). Counter runs only after init.
// - Not defined: no counter; refresh_late tied 0; refresh still produces a REFRESH_LAT busy window.
// TESTING
// - After rst, no requests -> busy=1, mem_initialized=0 for 16 cycles, then busy=0, mem_initialized=1.
// - write addr=0x10, din=0xDEADBEEF, mask=0x0, then read 0x10 -> busy 3 then 4 cycles; dout=0xDEADBEEF; total_written=1.
// - write 0x10, din=0x11223344, mask=0xA, then read -> dout=0xDE22BE44.
// - addr=0x4010 with DEPTH_WORDS=4096 -> aliases word 4; read 0x10 returns the same data.
// - read held high through busy window -> fail=1, busy stays 1 until read drops, then IDLE.
// - EN defined, no refresh for 406 post-init cycles -> refresh_late=1; refresh pulse -> busy 8 cycles, flag stays 1.

Source files
------------

// File: rtl/sdram_bram_responder.sv
// sdram_bram_responder: BRAM-backed SDRAM controller stand-in with controller-like timing; define SDRAM_BRAM_REFRESH_CHECK_EN for the refresh watchdog
module sdram_bram_responder #(
  parameter int    DEPTH_WORDS  = 4096,
  parameter int    READ_LAT     = 4,
  parameter int    WRITE_LAT    = 3,
  parameter int    REFRESH_LAT  = 8,
  parameter int    INIT_CYCLES  = 16,
  parameter int    REFRESH_MAX  = 405,
  parameter string PRELOAD_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic        refresh,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  mask,
  output logic [31:0] dout,
  output logic        busy,
  output logic        mem_initialized,
  output logic        fail,
  output logic [31:0] total_written,
  output logic        refresh_late
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR, S_REF, S_REL} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH_WORDS];
  logic [15:0] cnt, lat;
  logic [AW-1:0] idx;
  logic [31:0] wdat;
  logic [3:0] wmask;
  logic [2:0] req, seen;
  logic op, done, viol;
  assign req  = {write, read, refresh};
  assign op   = state == S_RD || state == S_WR || state == S_REF;
  assign lat  = state == S_RD ? 16'(READ_LAT) : state == S_WR ? 16'(WRITE_LAT) : 16'(REFRESH_LAT);
  assign done = op && cnt == lat - 16'd1;
  assign viol = |(req & ~seen);
  assign busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    case (state)
      S_INIT:  state_n = cnt == 16'(INIT_CYCLES - 1) ? S_IDLE : S_INIT;
      S_IDLE:  state_n = write ? S_WR : read ? S_RD : refresh ? S_REF : S_IDLE;
      S_REL:   state_n = req == 3'b000 ? S_IDLE : S_REL;
      default: state_n = done ? (viol ? S_REL : S_IDLE) : state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_INIT;
      cnt             <= '0;
      dout            <= '0;
      mem_initialized <= 1'b0;
      fail            <= 1'b0;
      total_written   <= '0;
      seen            <= '0;
      idx             <= '0;
      wdat            <= '0;
      wmask           <= '1;
    end else begin
      state <= state_n;
      cnt   <= state_n != state ? 16'd0 : cnt + 16'd1;
      if (state == S_INIT && state_n == S_IDLE) mem_initialized <= 1'b1;
      if (state == S_IDLE) begin
        idx   <= addr[AW+1:2];
        wdat  <= din;
        wmask <= mask;
        seen  <= '0;
        if (write && (read || refresh)) fail <= 1'b1;
      end else begin
        seen <= seen | ~req;
      end
      if (done && viol) fail <= 1'b1;
      if (done && state == S_RD) dout <= mem[idx];
      if (done && state == S_WR) total_written <= total_written + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (done && state == S_WR && !wmask[b]) mem[idx][b*8 +: 8] <= wdat[b*8 +: 8];
  end
`ifdef SDRAM_BRAM_REFRESH_CHECK_EN
  localparam int RW = $clog2(REFRESH_MAX + 2) + 1;
  logic [RW-1:0] rcnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt         <= '0;
      refresh_late <= 1'b0;
    end else begin
      if (done && state == S_REF) rcnt <= '0;
      else if (mem_initialized && rcnt != '1) rcnt <= rcnt + 1'b1;
      if (rcnt > RW'(REFRESH_MAX)) refresh_late <= 1'b1;
    end
  end
`else
  assign refresh_late = 1'b0;
`endif
endmodule
